// File: rtl/two_mode_timer_core_pkg.sv
// Shared state encoding, constants and preset clamping helpers for the two-mode timer.
package two_mode_timer_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } timerState_e;

  localparam logic [5:0] SEC_MAX   = 6'd59;
  localparam logic       MODE_UP   = 1'b0;
  localparam logic       MODE_DOWN = 1'b1;

  function automatic logic [6:0] clampMin(input logic [6:0] m, input logic [6:0] maxMin);
    return (m > maxMin) ? maxMin : m;
  endfunction

  function automatic logic [5:0] clampSec(input logic [5:0] s);
    return (s > SEC_MAX) ? SEC_MAX : s;
  endfunction

endpackage

// File: rtl/two_mode_timer_core_sec_prescaler.sv
// Divides the system clock down to one-second steps; holds its phase whenever en is low.
module sec_prescaler #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int         CntW    = $clog2(TICKS_PER_SEC);
  localparam logic [CntW-1:0] CntLast = CntW'(TICKS_PER_SEC - 1);

  logic [CntW-1:0] cnt_q;

  // tick marks the cycle whose edge completes a second, so the core steps on that same edge
  assign tick = en && (cnt_q == CntLast);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/two_mode_timer_core.sv
// Stopwatch / countdown timer: start-stop edge register, run-state FSM and min:sec arithmetic.
module two_mode_timer_core
  import two_mode_timer_core_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int MAX_MIN       = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       mode,
  input  logic       load,
  input  logic [6:0] preset_min,
  input  logic [5:0] preset_sec,
  output logic [6:0] minutes,
  output logic [5:0] seconds,
  output logic       active,
  output logic       paused,
  output logic       done,
  output logic       sec_tick
);

  localparam logic [6:0] MaxMinVal = 7'(MAX_MIN);

  timerState_e state_q;
  logic [6:0]  minutes_q;
  logic [5:0]  seconds_q;
  logic        mode_q;
  logic        ss_q;
  logic        active_q;
  logic        paused_q;
  logic        done_q;
  logic        tick_q;

  logic        ssEvt;
  logic        secWrap;
  logic        preEn;
  logic        preClr;
  logic        valueZero;
  logic [6:0]  loadMin_d;
  logic [5:0]  loadSec_d;
  logic [6:0]  stepMin_d;
  logic [5:0]  stepSec_d;
  logic        stepLast_d;

  // ss_q resets high so a start_stop already high at reset release is not an event
  assign ssEvt     = start_stop & ~ss_q;
  assign valueZero = (minutes_q == '0) && (seconds_q == '0);
  assign preEn     = (state_q == ST_RUN);
  assign preClr    = (state_q == ST_IDLE) || (state_q == ST_DONE) ||
                     ((state_q == ST_PAUSE) && load);

  sec_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (preEn),
    .clr  (preClr),
    .tick (secWrap)
  );

  always_comb begin
    loadMin_d = '0;
    loadSec_d = '0;
    if (mode == MODE_DOWN) begin
      loadMin_d = clampMin(preset_min, MaxMinVal);
      loadSec_d = clampSec(preset_sec);
    end
  end

  // One-second step in the latched direction; a value already at its end point holds
  always_comb begin
    stepMin_d  = minutes_q;
    stepSec_d  = seconds_q;
    stepLast_d = 1'b0;
    if (mode_q == MODE_UP) begin
      if ((minutes_q >= MaxMinVal) && (seconds_q >= SEC_MAX)) begin
        stepMin_d = minutes_q;
        stepSec_d = seconds_q;
      end else if (seconds_q >= SEC_MAX) begin
        stepSec_d = '0;
        stepMin_d = minutes_q + 7'd1;
      end else begin
        stepSec_d = seconds_q + 6'd1;
      end
      stepLast_d = (stepMin_d >= MaxMinVal) && (stepSec_d >= SEC_MAX);
    end else begin
      if (valueZero) begin
        stepMin_d = minutes_q;
        stepSec_d = seconds_q;
      end else if (seconds_q == '0) begin
        stepSec_d = SEC_MAX;
        stepMin_d = minutes_q - 7'd1;
      end else begin
        stepSec_d = seconds_q - 6'd1;
      end
      stepLast_d = (stepMin_d == '0) && (stepSec_d == '0);
    end
  end

  // Flags are updated alongside every state change so they always match state_q
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      minutes_q <= '0;
      seconds_q <= '0;
      mode_q    <= MODE_UP;
      ss_q      <= 1'b1;
      active_q  <= 1'b0;
      paused_q  <= 1'b0;
      done_q    <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      ss_q   <= start_stop;
      tick_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            minutes_q <= loadMin_d;
            seconds_q <= loadSec_d;
          end else if (ssEvt && !((mode == MODE_DOWN) && valueZero)) begin
            mode_q   <= mode;
            state_q  <= ST_RUN;
            active_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (secWrap) begin
            tick_q    <= 1'b1;
            minutes_q <= stepMin_d;
            seconds_q <= stepSec_d;
          end
          // Reaching the end point wins over a pause request on the same edge
          if (secWrap && stepLast_d) begin
            state_q  <= ST_DONE;
            active_q <= 1'b0;
            done_q   <= 1'b1;
          end else if (ssEvt) begin
            state_q  <= ST_PAUSE;
            active_q <= 1'b0;
            paused_q <= 1'b1;
          end
        end
        ST_PAUSE: begin
          if (load) begin
            minutes_q <= loadMin_d;
            seconds_q <= loadSec_d;
            state_q   <= ST_IDLE;
            paused_q  <= 1'b0;
          end else if (ssEvt) begin
            state_q  <= ST_RUN;
            paused_q <= 1'b0;
            active_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (load || ssEvt) begin
            minutes_q <= loadMin_d;
            seconds_q <= loadSec_d;
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign minutes  = minutes_q;
  assign seconds  = seconds_q;
  assign active   = active_q;
  assign paused   = paused_q;
  assign done     = done_q;
  assign sec_tick = tick_q;

endmodule

// File: tb/tb_two_mode_timer_core.sv
// Self-checking bench for two_mode_timer_core: vector table, directed corner sequences, random run vs. model.
module tb_two_mode_timer_core;

  localparam int Ticks    = 4;
  localparam int MaxMin   = 99;
  localparam int MaxTotal = MaxMin * 60 + 59;
  localparam int MIdle    = 0;
  localparam int MRun     = 1;
  localparam int MPause   = 2;
  localparam int MDone    = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       startStop;
  logic       mode;
  logic       load;
  logic [6:0] presetMin;
  logic [5:0] presetSec;
  logic [6:0] minutes;
  logic [5:0] seconds;
  logic       active;
  logic       paused;
  logic       done;
  logic       secTick;

  int testsRun    = 0;
  int testsFailed = 0;

  int mState  = MIdle;
  int mTotal  = 0;
  bit mModeQ  = 0;
  int mPhase  = 0;
  bit mSsPrev = 1;
  bit mTick   = 0;

  typedef struct {
    logic       rst;
    logic       ss;
    logic       mode;
    logic       load;
    logic [6:0] pmin;
    logic [5:0] psec;
    logic [6:0] emin;
    logic [5:0] esec;
    logic       eact;
    logic       epau;
    logic       edone;
    logic       etick;
  } vec_t;

  vec_t vecs [15];

  two_mode_timer_core #(
    .TICKS_PER_SEC(Ticks),
    .MAX_MIN      (MaxMin)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_stop (startStop),
    .mode       (mode),
    .load       (load),
    .preset_min (presetMin),
    .preset_sec (presetSec),
    .minutes    (minutes),
    .seconds    (seconds),
    .active     (active),
    .paused     (paused),
    .done       (done),
    .sec_tick   (secTick)
  );

  always #5 clk = ~clk;

  // Reference: value kept as total seconds, phase as RUN cycles since the last counted second
  task automatic modelEdge();
    bit evt;
    bit finished;
    int pm;
    int ps;
    int loadVal;
    if (rst) begin
      mState  = MIdle;
      mTotal  = 0;
      mModeQ  = 0;
      mPhase  = 0;
      mSsPrev = 1;
      mTick   = 0;
      return;
    end
    evt     = startStop && !mSsPrev;
    mSsPrev = startStop;
    mTick   = 0;
    pm      = (int'(presetMin) > MaxMin) ? MaxMin : int'(presetMin);
    ps      = (int'(presetSec) > 59) ? 59 : int'(presetSec);
    loadVal = mode ? pm * 60 + ps : 0;
    finished = 0;
    case (mState)
      MIdle: begin
        if (load) mTotal = loadVal;
        else if (evt && !(mode && mTotal == 0)) begin
          mModeQ = mode;
          mPhase = 0;
          mState = MRun;
        end
      end
      MRun: begin
        mPhase++;
        if (mPhase == Ticks) begin
          mPhase = 0;
          mTick  = 1;
          if (!mModeQ) begin
            if (mTotal < MaxTotal) mTotal++;
            finished = (mTotal == MaxTotal);
          end else begin
            if (mTotal > 0) mTotal--;
            finished = (mTotal == 0);
          end
        end
        if (finished) mState = MDone;
        else if (evt) mState = MPause;
      end
      MPause: begin
        if (load) begin
          mTotal = loadVal;
          mPhase = 0;
          mState = MIdle;
        end else if (evt) mState = MRun;
      end
      default: begin
        if (load || evt) begin
          mTotal = loadVal;
          mState = MIdle;
        end
      end
    endcase
  endtask

  function automatic logic [31:0] packOut(input logic [6:0] m, input logic [5:0] s,
                                          input logic a, input logic p, input logic d,
                                          input logic t);
    return {15'd0, m, s, a, p, d, t};
  endfunction

  task automatic applyStimulus(input bit r, input bit ss, input bit md, input bit ld,
                               input int pm, input int ps);
    rst       = r;
    startStop = ss;
    mode      = md;
    load      = ld;
    presetMin = 7'(pm);
    presetSec = 6'(ps);
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int tickCount;
    int entries;
    bit prevActive;
    bit ssRand;
    bit modeRand;

    rst = 1'b1; startStop = 1'b0; mode = 1'b0; load = 1'b0;
    presetMin = '0; presetSec = '0;

    //            rst ss md ld  pmin    psec    emin   esec  act pau dn tk
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,7'd0,  6'd0,  7'd0, 6'd0, 1'b0,1'b0,1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b0,1'b1,1'b1,7'd120,6'd63, 7'd99,6'd59,1'b0,1'b0,1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b1,1'b1,7'd0,  6'd0,  7'd0, 6'd0, 1'b0,1'b0,1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b1,1'b1,1'b0,7'd0,  6'd0,  7'd0, 6'd0, 1'b0,1'b0,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b0,1'b1,1'b0,7'd0,  6'd0,  7'd0, 6'd0, 1'b0,1'b0,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b0,1'b1,1'b1,7'd0,  6'd2,  7'd0, 6'd2, 1'b0,1'b0,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b1,1'b1,1'b0,7'd0,  6'd2,  7'd0, 6'd2, 1'b1,1'b0,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b0,1'b1,1'b1,7'd5,  6'd5,  7'd0, 6'd2, 1'b1,1'b0,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b0,1'b1,1'b0,7'd0,  6'd0,  7'd0, 6'd2, 1'b1,1'b0,1'b0,1'b0};
    vecs[9]  = '{1'b0,1'b0,1'b1,1'b0,7'd0,  6'd0,  7'd0, 6'd2, 1'b1,1'b0,1'b0,1'b0};
    vecs[10] = '{1'b0,1'b0,1'b1,1'b0,7'd0,  6'd0,  7'd0, 6'd1, 1'b1,1'b0,1'b0,1'b1};
    vecs[11] = '{1'b0,1'b1,1'b1,1'b0,7'd0,  6'd0,  7'd0, 6'd1, 1'b0,1'b1,1'b0,1'b0};
    vecs[12] = '{1'b0,1'b0,1'b1,1'b0,7'd0,  6'd0,  7'd0, 6'd1, 1'b0,1'b1,1'b0,1'b0};
    vecs[13] = '{1'b0,1'b1,1'b1,1'b1,7'd3,  6'd4,  7'd3, 6'd4, 1'b0,1'b0,1'b0,1'b0};
    vecs[14] = '{1'b0,1'b0,1'b1,1'b0,7'd3,  6'd4,  7'd3, 6'd4, 1'b0,1'b0,1'b0,1'b0};

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].ss, vecs[i].mode, vecs[i].load,
                    int'(vecs[i].pmin), int'(vecs[i].psec));
      checkOutput($sformatf("vec%0d", i),
                  packOut(minutes, seconds, active, paused, done, secTick),
                  packOut(vecs[i].emin, vecs[i].esec, vecs[i].eact, vecs[i].epau,
                          vecs[i].edone, vecs[i].etick));
    end

    // Stopwatch: 40 clocks after the start event is ten counted seconds
    doReset();
    applyStimulus(0, 1, 0, 0, 0, 0);
    tickCount = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      tickCount += int'(secTick);
    end
    checkOutput("sw_value", packOut(minutes, seconds, active, 0, 0, 0), packOut(7'd0, 6'd10, 1, 0, 0, 0));
    checkOutput("sw_ticks", tickCount, 10);

    // Countdown 01:01 to DONE, then start_stop returns to IDLE at the preset
    doReset();
    applyStimulus(0, 0, 1, 1, 1, 1);
    applyStimulus(0, 1, 1, 0, 1, 1);
    for (int i = 1; i <= 244; i++) begin
      applyStimulus(0, 0, 1, 0, 1, 1);
      if (i == 4)   checkOutput("cd_1s", packOut(minutes, seconds, 0, 0, 0, 0), packOut(7'd1, 6'd0, 0, 0, 0, 0));
      if (i == 8)   checkOutput("cd_2s", packOut(minutes, seconds, 0, 0, 0, 0), packOut(7'd0, 6'd59, 0, 0, 0, 0));
      if (i == 243) checkOutput("cd_not_done", done, 1'b0);
    end
    checkOutput("cd_done", packOut(minutes, seconds, active, paused, done, 0), packOut(7'd0, 6'd0, 0, 0, 1, 0));
    applyStimulus(0, 1, 1, 0, 1, 1);
    checkOutput("cd_reload", packOut(minutes, seconds, active, paused, done, 0), packOut(7'd1, 6'd1, 0, 0, 0, 0));

    // Pause with the prescaler at 2, stay paused 20 clocks, resume
    doReset();
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("pause_enter", packOut(0, 0, active, paused, 0, 0), packOut(0, 0, 0, 1, 0, 0));
    applyStimulus(0, 0, 0, 0, 0, 0);
    tickCount = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      tickCount += int'(secTick);
    end
    checkOutput("pause_no_tick", tickCount, 0);
    checkOutput("pause_hold", packOut(minutes, seconds, 0, paused, 0, 0), packOut(7'd0, 6'd0, 0, 1, 0, 0));
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("resume_evt", packOut(0, 0, active, 0, 0, secTick), packOut(0, 0, 1, 0, 0, 0));
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("resume_tick", packOut(0, seconds, 0, 0, 0, secTick), packOut(0, 6'd1, 0, 0, 0, 1));

    // Held start_stop gives one RUN entry; a level present at reset release gives none
    doReset();
    entries = 0;
    prevActive = 0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0);
      if (active && !prevActive) entries++;
      prevActive = active;
    end
    checkOutput("held_entries", entries, 1);
    checkOutput("held_paused", paused, 1'b0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    entries = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0);
      entries += int'(active);
    end
    checkOutput("rst_release_idle", entries, 0);

    // Stopwatch started from 99:58 saturates at 99:59
    doReset();
    applyStimulus(0, 0, 1, 1, 99, 58);
    applyStimulus(0, 0, 0, 0, 99, 58);
    applyStimulus(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("sat_pre", packOut(minutes, seconds, active, 0, done, 0), packOut(7'd99, 6'd58, 1, 0, 0, 0));
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("sat_done", packOut(minutes, seconds, active, 0, done, 0), packOut(7'd99, 6'd59, 0, 0, 1, 0));
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("sat_hold", packOut(minutes, seconds, active, 0, done, 0), packOut(7'd99, 6'd59, 0, 0, 1, 0));

    // start_stop event on the wrap edge: step applied and PAUSE entered
    doReset();
    applyStimulus(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("collide", packOut(minutes, seconds, active, paused, done, secTick), packOut(7'd0, 6'd1, 0, 1, 0, 1));

    // Reset mid-run wins over simultaneous load and start_stop
    doReset();
    applyStimulus(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 28; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("run_7s", packOut(minutes, seconds, active, 0, 0, 0), packOut(7'd0, 6'd7, 1, 0, 0, 0));
    applyStimulus(1, 1, 1, 1, 5, 5);
    checkOutput("rst_mid_run", packOut(minutes, seconds, active, paused, done, secTick), packOut(0, 0, 0, 0, 0, 0));

    // Random traffic compared every cycle against the reference model
    doReset();
    ssRand = 0;
    modeRand = 0;
    for (int i = 0; i < 4000; i++) begin
      int pm;
      int ps;
      if ($urandom_range(0, 9) == 0) ssRand = ~ssRand;
      if ($urandom_range(0, 14) == 0) modeRand = ~modeRand;
      pm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 1));
      ps = int'($urandom_range(0, 63));
      applyStimulus($urandom_range(0, 299) == 0, ssRand, modeRand, $urandom_range(0, 24) == 0, pm, ps);
      checkOutput($sformatf("rand%0d", i),
                  packOut(minutes, seconds, active, paused, done, secTick),
                  packOut(7'(mTotal / 60), 6'(mTotal % 60), mState == MRun, mState == MPause,
                          mState == MDone, mTick));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
